// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite word-addressable RAM slave: independent write/read FSMs, byte strobes, read wait states, SLVERR out of range.
// Define AXI_LITE_RAM_PROT_CHECK_EN to reject unprivileged (PROT[0]=0) accesses with SLVERR.
module axi_lite_ram_slave #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    MEM_DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    RD_WAIT_CYCLES = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
  input  logic [2:0]              S_AWPROT,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
  input  logic [2:0]              S_ARPROT,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  output logic                    S_RLAST,
  input  logic                    S_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_W);

  // Extra MSB on the offset so BASE_ADDR + SPAN can reach the top of the address space.
  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> LSB);
  endfunction

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  wr_state_t             r_wr_state, w_wr_next;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_awprot0;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [1:0]            r_bresp;
  logic                  w_awready, w_wready, w_bvalid;
  logic                  w_commit, w_lat_aw, w_lat_w;
  logic [ADDR_WIDTH-1:0] w_cm_addr;
  logic                  w_cm_prot0;
  logic [DATA_WIDTH-1:0] w_cm_data;
  logic [STRB_W-1:0]     w_cm_strb;
  logic                  w_wr_prot_ok, w_wr_ok;
  logic [IDX_W-1:0]      w_wr_idx;

  rd_state_t             r_rd_state, w_rd_next;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arprot0;
  logic [3:0]            r_rcnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_arready, w_rvalid, w_lat_ar, w_rd_capture;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_prot0;
  logic                  w_rd_prot_ok, w_rd_ok;
  logic                  w_unused;

  // ---------------- write path ----------------
  always_comb begin
    w_wr_next = r_wr_state;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    w_commit  = 1'b0;
    w_lat_aw  = 1'b0;
    w_lat_w   = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        w_awready = 1'b1;
        w_wready  = 1'b1;
        if (S_AWVALID && S_WVALID) begin
          w_commit  = 1'b1;
          w_wr_next = WR_RESP;
        end else if (S_AWVALID) begin
          w_lat_aw  = 1'b1;
          w_wr_next = WR_HAVE_AW;
        end else if (S_WVALID) begin
          w_lat_w   = 1'b1;
          w_wr_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        w_wready = 1'b1;
        if (S_WVALID) begin
          w_commit  = 1'b1;
          w_wr_next = WR_RESP;
        end
      end
      WR_HAVE_W: begin
        w_awready = 1'b1;
        if (S_AWVALID) begin
          w_commit  = 1'b1;
          w_wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        w_bvalid = 1'b1;
        if (S_BREADY) w_wr_next = WR_IDLE;
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  assign w_cm_addr  = (r_wr_state == WR_HAVE_AW) ? r_awaddr  : S_AWADDR;
  assign w_cm_prot0 = (r_wr_state == WR_HAVE_AW) ? r_awprot0 : S_AWPROT[0];
  assign w_cm_data  = (r_wr_state == WR_HAVE_W)  ? r_wdata   : S_WDATA;
  assign w_cm_strb  = (r_wr_state == WR_HAVE_W)  ? r_wstrb   : S_WSTRB;
  assign w_wr_ok    = f_in_range(w_cm_addr) && w_wr_prot_ok;
  assign w_wr_idx   = f_idx(w_cm_addr);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_state <= WR_IDLE;
      r_awaddr   <= '0;
      r_awprot0  <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= 2'b00;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_lat_aw) begin
        r_awaddr  <= S_AWADDR;
        r_awprot0 <= S_AWPROT[0];
      end
      if (w_lat_w) begin
        r_wdata <= S_WDATA;
        r_wstrb <= S_WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_ok ? 2'b00 : 2'b10;
    end
  end

  // Memory survives reset, so it has no reset branch.
  always_ff @(posedge ACLK) begin
    if (w_commit && w_wr_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_cm_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_cm_data[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    w_rd_next = r_rd_state;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    w_lat_ar  = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        w_arready = 1'b1;
        if (S_ARVALID) begin
          w_lat_ar  = 1'b1;
          w_rd_next = (RD_WAIT_CYCLES != 0) ? RD_WAIT : RD_RESP;
        end
      end
      RD_WAIT: begin
        if (r_rcnt <= 4'd1) w_rd_next = RD_RESP;
      end
      RD_RESP: begin
        w_rvalid = 1'b1;
        if (S_RREADY) w_rd_next = RD_IDLE;
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  assign w_rd_capture = (w_rd_next == RD_RESP) && (r_rd_state != RD_RESP);
  assign w_rd_addr    = (r_rd_state == RD_IDLE) ? S_ARADDR    : r_araddr;
  assign w_rd_prot0   = (r_rd_state == RD_IDLE) ? S_ARPROT[0] : r_arprot0;
  assign w_rd_ok      = f_in_range(w_rd_addr) && w_rd_prot_ok;

  // Capture reads the array with the pre-edge value, giving read-before-write on collisions.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rd_state <= RD_IDLE;
      r_araddr   <= '0;
      r_arprot0  <= 1'b0;
      r_rcnt     <= 4'd0;
      r_rdata    <= '0;
      r_rresp    <= 2'b00;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_lat_ar) begin
        r_araddr  <= S_ARADDR;
        r_arprot0 <= S_ARPROT[0];
        r_rcnt    <= 4'(RD_WAIT_CYCLES);
      end else if (r_rd_state == RD_WAIT) begin
        r_rcnt <= r_rcnt - 4'd1;
      end
      if (w_rd_capture) begin
        r_rdata <= w_rd_ok ? r_mem[f_idx(w_rd_addr)] : '0;
        r_rresp <= w_rd_ok ? 2'b00 : 2'b10;
      end
    end
  end

`ifdef AXI_LITE_RAM_PROT_CHECK_EN
  assign w_wr_prot_ok = w_cm_prot0;
  assign w_rd_prot_ok = w_rd_prot0;
  assign w_unused     = ^{S_AWPROT[2:1], S_ARPROT[2:1]};
`else
  assign w_wr_prot_ok = 1'b1;
  assign w_rd_prot_ok = 1'b1;
  assign w_unused     = ^{S_AWPROT, S_ARPROT, w_cm_prot0, w_rd_prot0};
`endif

  assign S_AWREADY = w_awready;
  assign S_WREADY  = w_wready;
  assign S_BVALID  = w_bvalid;
  assign S_BRESP   = r_bresp;
  assign S_ARREADY = w_arready;
  assign S_RVALID  = w_rvalid;
  assign S_RLAST   = w_rvalid;
  assign S_RDATA   = r_rdata;
  assign S_RRESP   = r_rresp;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed bench for axi_lite_ram_slave (32-bit data, 1024 words, base 0, two read wait states).
module tb_axi_lite_ram_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] S_AWADDR;
  logic [2:0]  S_AWPROT;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [31:0] S_ARADDR;
  logic [2:0]  S_ARPROT;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RLAST;
  logic        S_RREADY;

  int n_pass  = 0;
  int n_total = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_ram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
    .BASE_ADDR(32'h0000_0000), .RD_WAIT_CYCLES(2)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RLAST(S_RLAST),
    .S_RREADY(S_RREADY)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    S_AWADDR = a; S_AWVALID = 1'b1;
    S_WDATA = d; S_WSTRB = s; S_WVALID = 1'b1; S_BREADY = 1'b0;
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    lat = 1;
    while (!S_BVALID && lat < 20) begin
      @(posedge ACLK); #1;
      lat++;
    end
    if (!S_BVALID) lat = -1;
    resp = S_BRESP;
    S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output logic last, output int lat);
    S_ARADDR = a; S_ARVALID = 1'b1; S_RREADY = 1'b0;
    @(posedge ACLK); #1;
    S_ARVALID = 1'b0;
    lat = 1;
    while (!S_RVALID && lat < 20) begin
      @(posedge ACLK); #1;
      lat++;
    end
    if (!S_RVALID) lat = -1;
    d = S_RDATA; resp = S_RRESP; last = S_RLAST;
    S_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (5) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    #1;
    n_total++; if (S_AWREADY !== 1'b1) $display("FAIL rst_awready got=%b exp=1", S_AWREADY); else n_pass++;
    n_total++; if (S_WREADY  !== 1'b1) $display("FAIL rst_wready got=%b exp=1", S_WREADY);  else n_pass++;
    n_total++; if (S_ARREADY !== 1'b1) $display("FAIL rst_arready got=%b exp=1", S_ARREADY); else n_pass++;
    n_total++; if (S_BVALID  !== 1'b0) $display("FAIL rst_bvalid got=%b exp=0", S_BVALID);  else n_pass++;
    n_total++; if (S_RVALID  !== 1'b0) $display("FAIL rst_rvalid got=%b exp=0", S_RVALID);  else n_pass++;
    n_total++; if (S_RLAST   !== 1'b0) $display("FAIL rst_rlast got=%b exp=0", S_RLAST);    else n_pass++;
    n_total++; if (S_BRESP   !== 2'b00) $display("FAIL rst_bresp got=%b exp=00", S_BRESP);  else n_pass++;
    n_total++; if (S_RRESP   !== 2'b00) $display("FAIL rst_rresp got=%b exp=00", S_RRESP);  else n_pass++;
    n_total++; if (S_RDATA   !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", S_RDATA);   else n_pass++;
    @(posedge ACLK); #1;
  endtask

  task automatic test_write_read();
    logic [1:0] resp; logic [31:0] d; logic last; int lat;
    do_write(32'h10, 32'hAAAA_0001, 4'hF, resp, lat);
    n_total++; if (lat !== 1) $display("FAIL wr_latency got=%0d exp=1", lat); else n_pass++;
    n_total++; if (resp !== 2'b00) $display("FAIL wr_bresp got=%b exp=00", resp); else n_pass++;
    do_read(32'h10, d, resp, last, lat);
    n_total++; if (lat !== 3) $display("FAIL rd_latency got=%0d exp=3", lat); else n_pass++;
    n_total++; if (d !== 32'hAAAA_0001) $display("FAIL rd_data got=%h exp=aaaa0001", d); else n_pass++;
    n_total++; if (resp !== 2'b00) $display("FAIL rd_rresp got=%b exp=00", resp); else n_pass++;
    n_total++; if (last !== 1'b1) $display("FAIL rd_rlast got=%b exp=1", last); else n_pass++;
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [31:0] d; logic last; int lat;
    S_WDATA = 32'h1234_5678; S_WSTRB = 4'b0011; S_WVALID = 1'b1; S_AWVALID = 1'b0;
    @(posedge ACLK); #1;
    S_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (S_WREADY !== 1'b0) $display("FAIL wfirst_wready cyc=%0d got=%b exp=0", i, S_WREADY); else n_pass++;
      n_total++; if (S_BVALID !== 1'b0) $display("FAIL wfirst_bvalid cyc=%0d got=%b exp=0", i, S_BVALID); else n_pass++;
      if (i < 2) begin
        @(posedge ACLK); #1;
      end
    end
    n_total++; if (S_AWREADY !== 1'b1) $display("FAIL wfirst_awready got=%b exp=1", S_AWREADY); else n_pass++;
    S_AWADDR = 32'h10; S_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0;
    n_total++; if (S_BVALID !== 1'b1) $display("FAIL wfirst_bvalid_after_aw got=%b exp=1", S_BVALID); else n_pass++;
    n_total++; if (S_BRESP !== 2'b00) $display("FAIL wfirst_bresp got=%b exp=00", S_BRESP); else n_pass++;
    S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_BREADY = 1'b0;
    do_read(32'h10, d, resp, last, lat);
    n_total++; if (d !== 32'hAAAA_5678) $display("FAIL strobe_merge got=%h exp=aaaa5678", d); else n_pass++;
  endtask

  task automatic test_b_backpressure();
    logic [1:0] resp; logic [31:0] d; logic last; int lat;
    S_AWADDR = 32'h14; S_AWVALID = 1'b1;
    S_WDATA = 32'h0000_0055; S_WSTRB = 4'hF; S_WVALID = 1'b1; S_BREADY = 1'b0;
    @(posedge ACLK); #1;
    S_WVALID = 1'b0;
    S_AWADDR = 32'h18;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (S_BVALID !== 1'b1) $display("FAIL bp_bvalid cyc=%0d got=%b exp=1", i, S_BVALID); else n_pass++;
      n_total++; if (S_BRESP !== 2'b00) $display("FAIL bp_bresp cyc=%0d got=%b exp=00", i, S_BRESP); else n_pass++;
      n_total++; if (S_AWREADY !== 1'b0) $display("FAIL bp_awready cyc=%0d got=%b exp=0", i, S_AWREADY); else n_pass++;
      n_total++; if (S_WREADY !== 1'b0) $display("FAIL bp_wready cyc=%0d got=%b exp=0", i, S_WREADY); else n_pass++;
      @(posedge ACLK); #1;
    end
    S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_BREADY = 1'b0;
    n_total++; if (S_BVALID !== 1'b0) $display("FAIL bp_bvalid_drop got=%b exp=0", S_BVALID); else n_pass++;
    n_total++; if (S_AWREADY !== 1'b1) $display("FAIL bp_aw_not_yet got=%b exp=1", S_AWREADY); else n_pass++;
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0;
    n_total++; if (S_AWREADY !== 1'b0) $display("FAIL bp_aw_taken_awready got=%b exp=0", S_AWREADY); else n_pass++;
    n_total++; if (S_WREADY !== 1'b1) $display("FAIL bp_aw_taken_wready got=%b exp=1", S_WREADY); else n_pass++;
    S_WDATA = 32'h0000_0066; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_WVALID = 1'b0;
    n_total++; if (S_BVALID !== 1'b1) $display("FAIL bp_second_bvalid got=%b exp=1", S_BVALID); else n_pass++;
    S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_BREADY = 1'b0;
    do_read(32'h18, d, resp, last, lat);
    n_total++; if (d !== 32'h0000_0066) $display("FAIL bp_second_data got=%h exp=00000066", d); else n_pass++;
    do_read(32'h14, d, resp, last, lat);
    n_total++; if (d !== 32'h0000_0055) $display("FAIL bp_first_data got=%h exp=00000055", d); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] d; logic last; int lat;
    do_write(32'h0, 32'h0BAD_F00D, 4'hF, resp, lat);
    n_total++; if (resp !== 2'b00) $display("FAIL oor_word0_bresp got=%b exp=00", resp); else n_pass++;
    do_write(32'hFFC, 32'hC0DE_0FFC, 4'hF, resp, lat);
    n_total++; if (resp !== 2'b00) $display("FAIL oor_lastword_bresp got=%b exp=00", resp); else n_pass++;
    do_write(32'h1000, 32'hDEAD_BEEF, 4'hF, resp, lat);
    n_total++; if (resp !== 2'b10) $display("FAIL oor_bresp got=%b exp=10", resp); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL oor_wr_latency got=%0d exp=1", lat); else n_pass++;
    do_read(32'h1000, d, resp, last, lat);
    n_total++; if (resp !== 2'b10) $display("FAIL oor_rresp got=%b exp=10", resp); else n_pass++;
    n_total++; if (d !== 32'h0) $display("FAIL oor_rdata got=%h exp=00000000", d); else n_pass++;
    do_read(32'h0, d, resp, last, lat);
    n_total++; if (d !== 32'h0BAD_F00D) $display("FAIL oor_word0_kept got=%h exp=0badf00d", d); else n_pass++;
    do_read(32'hFFC, d, resp, last, lat);
    n_total++; if (d !== 32'hC0DE_0FFC) $display("FAIL oor_lastword got=%h exp=c0de0ffc", d); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] resp; logic [31:0] d; logic last; int lat;
    S_ARADDR = 32'h10; S_ARVALID = 1'b1; S_RREADY = 1'b0;
    @(posedge ACLK); #1;
    S_ARVALID = 1'b0;
    repeat (2) begin
      @(posedge ACLK); #1;
    end
    n_total++; if (S_RVALID !== 1'b1) $display("FAIL mid_rvalid_before got=%b exp=1", S_RVALID); else n_pass++;
    #2;
    ARESETN = 1'b0;
    #1;
    n_total++; if (S_RVALID !== 1'b0) $display("FAIL mid_rvalid_async got=%b exp=0", S_RVALID); else n_pass++;
    n_total++; if (S_RLAST !== 1'b0) $display("FAIL mid_rlast_async got=%b exp=0", S_RLAST); else n_pass++;
    n_total++; if (S_ARREADY !== 1'b1) $display("FAIL mid_arready_async got=%b exp=1", S_ARREADY); else n_pass++;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    do_read(32'h10, d, resp, last, lat);
    n_total++; if (lat !== 3) $display("FAIL mid_after_latency got=%0d exp=3", lat); else n_pass++;
    n_total++; if (resp !== 2'b00) $display("FAIL mid_after_rresp got=%b exp=00", resp); else n_pass++;
    n_total++; if (d !== 32'hAAAA_5678) $display("FAIL mid_after_rdata got=%h exp=aaaa5678", d); else n_pass++;
  endtask

  initial begin
    ARESETN = 1'b0;
    S_AWADDR = '0; S_AWPROT = 3'b001; S_AWVALID = 1'b0;
    S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0; S_BREADY = 1'b0;
    S_ARADDR = '0; S_ARPROT = 3'b001; S_ARVALID = 1'b0; S_RREADY = 1'b0;
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_b_backpressure();
    test_out_of_range();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
